// File: rtl/bomberman_copy_engine.sv
// Copies a background or 8x8 sprite ROM region to the VGA write port, one pixel per cycle.
// Latency: first address 1 cycle after accept, pixel 1 cycle after its address; no backpressure, job runs to completion.
module bomberman_copy_engine #(
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int SPRITE_SZ = 8,
    parameter int COLOUR_W  = 3,
    parameter int ADDR_W    = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                copy_enable,
    input  logic [1:0]          memory_select,
    input  logic                draw_t,
    input  logic                draw_p1,
    input  logic                draw_p2,
    input  logic [4:0]          tile_x,
    input  logic [3:0]          tile_y,
    input  logic [1:0]          tile_id,
    input  logic [7:0]          p1_x,
    input  logic [7:0]          p2_x,
    input  logic [6:0]          p1_y,
    input  logic [6:0]          p2_y,
    output logic [1:0]          rom_select,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                finished
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic                bg_q, bg_d;
    logic                trans_q, trans_d;
    logic [8:0]          ox_q, ox_d;
    logic [7:0]          oy_q, oy_d;
    logic [7:0]          col_q, col_d;
    logic [6:0]          row_q, row_d;
    logic [1:0]          rom_select_q, rom_select_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [7:0]          vga_x_q, vga_x_d;
    logic [6:0]          vga_y_q, vga_y_d;
    logic                pix_vld_q, pix_vld_d;
    logic                finished_q, finished_d;

    logic [8:0]          x_sum;
    logic [7:0]          y_sum;
    logic [7:0]          col_last;
    logic [6:0]          row_last;
    logic [2:0]          idx;

    assign x_sum    = ox_q + 9'(col_q);
    assign y_sum    = oy_q + 8'(row_q);
    assign col_last = bg_q ? 8'(SCREEN_W - 1) : 8'(SPRITE_SZ - 1);
    assign row_last = bg_q ? 7'(SCREEN_H - 1) : 7'(SPRITE_SZ - 1);

    always_comb begin
        state_d      = state_q;
        bg_d         = bg_q;
        trans_d      = trans_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        col_d        = col_q;
        row_d        = row_q;
        rom_select_d = rom_select_q;
        rom_addr_d   = rom_addr_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        pix_vld_d    = 1'b0;
        finished_d   = 1'b0;
        idx          = 3'd0;

        case (state_q)
            IDLE: begin
                if (copy_enable) begin
                    rom_select_d = memory_select;
                    col_d        = '0;
                    row_d        = '0;
                    state_d      = RUN;
                    if (memory_select != 2'd3) begin
                        bg_d    = 1'b1;
                        trans_d = 1'b0;
                        ox_d    = '0;
                        oy_d    = '0;
                    end else begin
                        bg_d = 1'b0;
                        // Tile wins over players; a sprite job with no draw_* flag falls back to tile.
                        if (draw_t || (!draw_p1 && !draw_p2)) begin
                            idx     = {1'b0, tile_id};
                            trans_d = 1'b0;
                            ox_d    = 9'(tile_x) * 9'(SPRITE_SZ);
                            oy_d    = 8'(tile_y) * 8'(SPRITE_SZ);
                        end else if (draw_p1) begin
                            idx     = 3'd4;
                            trans_d = 1'b1;
                            ox_d    = {1'b0, p1_x};
                            oy_d    = {1'b0, p1_y};
                        end else begin
                            idx     = 3'd5;
                            trans_d = 1'b1;
                            ox_d    = {1'b0, p2_x};
                            oy_d    = {1'b0, p2_y};
                        end
                    end
                    // Both region layouts are row-major with col fastest, so addresses just increment.
                    rom_addr_d = bg_d ? '0 : ADDR_W'(idx) * ADDR_W'(SPRITE_SZ * SPRITE_SZ);
                end
            end
            RUN: begin
                vga_x_d   = x_sum[7:0];
                vga_y_d   = y_sum[6:0];
                pix_vld_d = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));
                if (col_q == col_last && row_q == row_last) begin
                    state_d = DRAIN;
                end else begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    if (col_q == col_last) begin
                        col_d = '0;
                        row_d = row_q + 7'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                finished_d = 1'b1;
                state_d    = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            bg_q         <= 1'b0;
            trans_q      <= 1'b0;
            ox_q         <= '0;
            oy_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            rom_select_q <= '0;
            rom_addr_q   <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            pix_vld_q    <= 1'b0;
            finished_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bg_q         <= bg_d;
            trans_q      <= trans_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            col_q        <= col_d;
            row_q        <= row_d;
            rom_select_q <= rom_select_d;
            rom_addr_q   <= rom_addr_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            pix_vld_q    <= pix_vld_d;
            finished_q   <= finished_d;
        end
    end

    // rom_data arrives in the same cycle as its registered coordinates, so colour and transparency stay combinational.
    assign rom_select = rom_select_q;
    assign rom_addr   = rom_addr_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = pix_vld_q ? rom_data : '0;
    assign vga_plot   = pix_vld_q && !(trans_q && rom_data == '0);
    assign finished   = finished_q;

endmodule

// File: tb/tb_bomberman_copy_engine.sv
// Directed bench for bomberman_copy_engine: per-scenario tasks with hand-computed expectations.
module tb_bomberman_copy_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        copy_enable;
    logic [1:0]  memory_select;
    logic        draw_t, draw_p1, draw_p2;
    logic [4:0]  tile_x;
    logic [3:0]  tile_y;
    logic [1:0]  tile_id;
    logic [7:0]  p1_x, p2_x;
    logic [6:0]  p1_y, p2_y;
    logic [1:0]  rom_select;
    logic [14:0] rom_addr;
    logic [2:0]  rom_data = 3'd0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        finished;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit rom_mode = 1'b0;

    int r_first_addr, r_last_addr, r_addr_bad, r_plots, r_pos_bad, r_col_bad, r_win_bad;
    int r_fin_k, r_fin_cnt, r_fx, r_fy, r_lx, r_ly;

    bomberman_copy_engine dut (
        .clock(clock), .reset(reset), .copy_enable(copy_enable), .memory_select(memory_select),
        .draw_t(draw_t), .draw_p1(draw_p1), .draw_p2(draw_p2),
        .tile_x(tile_x), .tile_y(tile_y), .tile_id(tile_id),
        .p1_x(p1_x), .p2_x(p2_x), .p1_y(p1_y), .p2_y(p2_y),
        .rom_select(rom_select), .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .finished(finished)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Mode 1 makes every even address (even column) colour 0.
    function automatic logic [2:0] romf(input logic [14:0] a);
        if (rom_mode && !a[0]) return 3'd0;
        return a[2:0];
    endfunction

    always @(posedge clock) rom_data <= romf(rom_addr);

    // Drives one job from a negedge and records what the DUT did, relative to the accept cycle.
    task automatic run_job(input int n, input int w, input int ox, input int oy, input bit hold, input bit scramble);
        int c0;
        int i;
        logic [14:0] prev_addr;
        r_first_addr = -1; r_last_addr = -1; r_addr_bad = 0; r_plots = 0; r_pos_bad = 0;
        r_col_bad = 0; r_win_bad = 0; r_fin_k = -1; r_fin_cnt = 0;
        r_fx = -1; r_fy = -1; r_lx = -1; r_ly = -1;
        prev_addr = rom_addr;
        copy_enable = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clock);
            if (cyc != c0 + k) r_win_bad++;
            if (k <= n) begin
                if (k == 1) r_first_addr = int'(rom_addr);
                else if (int'(rom_addr) != r_first_addr + k - 1) r_addr_bad++;
                r_last_addr = int'(rom_addr);
            end
            if (vga_plot === 1'b1) begin
                r_plots++;
                if (k < 2 || k > n + 1) r_win_bad++;
                else begin
                    i = k - 2;
                    if (int'(vga_x) != ox + i % w || int'(vga_y) != oy + i / w) r_pos_bad++;
                end
                if (vga_colour !== romf(prev_addr)) r_col_bad++;
                if (r_plots == 1) begin r_fx = int'(vga_x); r_fy = int'(vga_y); end
                r_lx = int'(vga_x); r_ly = int'(vga_y);
            end
            if (finished === 1'b1) begin
                r_fin_cnt++;
                r_fin_k = k;
                if (!hold) copy_enable = 1'b0;
            end
            if (scramble && k == 5) begin
                copy_enable = 1'b0; memory_select = 2'd0; tile_x = 5'd9; tile_y = 4'd1;
                tile_id = 2'd3; draw_t = 1'b0; draw_p1 = 1'b1;
            end
            prev_addr = rom_addr;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; copy_enable = 1'b0; memory_select = 2'd0;
        draw_t = 1'b0; draw_p1 = 1'b0; draw_p2 = 1'b0;
        tile_x = '0; tile_y = '0; tile_id = '0; p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0;
        repeat (3) @(negedge clock);
        vectors++; if (rom_select !== 2'd0) begin miscompares++; $display("FAIL reset_rom_select: got %0d want 0", rom_select); end
        vectors++; if (rom_addr !== 15'd0) begin miscompares++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
        vectors++; if (vga_x !== 8'd0 || vga_y !== 7'd0) begin miscompares++; $display("FAIL reset_vga_xy: got (%0d,%0d) want (0,0)", vga_x, vga_y); end
        vectors++; if (vga_colour !== 3'd0) begin miscompares++; $display("FAIL reset_vga_colour: got %0d want 0", vga_colour); end
        vectors++; if (vga_plot !== 1'b0 || finished !== 1'b0) begin miscompares++; $display("FAIL reset_plot_finished: got plot=%b fin=%b want 0 0", vga_plot, finished); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        vectors++; if (vga_plot !== 1'b0 || rom_addr !== 15'd0) begin miscompares++; $display("FAIL idle_after_reset: got plot=%b addr=%0d want 0 0", vga_plot, rom_addr); end
    endtask

    task automatic test_background();
        rom_mode = 1'b0; memory_select = 2'd0;
        run_job(19200, 160, 0, 0, 1'b0, 1'b0);
        vectors++; if (r_first_addr != 0 || r_last_addr != 19199) begin miscompares++; $display("FAIL bg_addr_range: got %0d..%0d want 0..19199", r_first_addr, r_last_addr); end
        vectors++; if (r_addr_bad != 0) begin miscompares++; $display("FAIL bg_addr_seq: got %0d bad want 0", r_addr_bad); end
        vectors++; if (r_plots != 19200) begin miscompares++; $display("FAIL bg_plot_count: got %0d want 19200", r_plots); end
        vectors++; if (r_pos_bad != 0 || r_win_bad != 0) begin miscompares++; $display("FAIL bg_plot_pos: got pos=%0d win=%0d want 0 0", r_pos_bad, r_win_bad); end
        vectors++; if (r_col_bad != 0) begin miscompares++; $display("FAIL bg_colour: got %0d bad want 0", r_col_bad); end
        vectors++; if (r_fx != 0 || r_fy != 0 || r_lx != 159 || r_ly != 119) begin miscompares++; $display("FAIL bg_first_last: got (%0d,%0d)..(%0d,%0d) want (0,0)..(159,119)", r_fx, r_fy, r_lx, r_ly); end
        vectors++; if (r_fin_k != 19202 || r_fin_cnt != 1) begin miscompares++; $display("FAIL bg_finished: got k=%0d n=%0d want 19202 1", r_fin_k, r_fin_cnt); end
        vectors++; if (rom_select !== 2'd0) begin miscompares++; $display("FAIL bg_rom_select: got %0d want 0", rom_select); end
    endtask

    task automatic test_tile();
        rom_mode = 1'b0; memory_select = 2'd3; draw_t = 1'b1; draw_p1 = 1'b0; draw_p2 = 1'b0;
        tile_x = 5'd3; tile_y = 4'd2; tile_id = 2'd1;
        run_job(64, 8, 24, 16, 1'b0, 1'b1);
        vectors++; if (r_first_addr != 64 || r_last_addr != 127 || r_addr_bad != 0) begin miscompares++; $display("FAIL tile_addr: got %0d..%0d bad=%0d want 64..127 0", r_first_addr, r_last_addr, r_addr_bad); end
        vectors++; if (r_plots != 64 || r_pos_bad != 0 || r_win_bad != 0) begin miscompares++; $display("FAIL tile_plots: got n=%0d pos=%0d win=%0d want 64 0 0", r_plots, r_pos_bad, r_win_bad); end
        vectors++; if (r_fx != 24 || r_fy != 16 || r_lx != 31 || r_ly != 23) begin miscompares++; $display("FAIL tile_first_last: got (%0d,%0d)..(%0d,%0d) want (24,16)..(31,23)", r_fx, r_fy, r_lx, r_ly); end
        vectors++; if (r_fin_k != 66 || r_fin_cnt != 1) begin miscompares++; $display("FAIL tile_finished: got k=%0d n=%0d want 66 1", r_fin_k, r_fin_cnt); end
        vectors++; if (rom_select !== 2'd3 || r_col_bad != 0) begin miscompares++; $display("FAIL tile_select_colour: got sel=%0d colbad=%0d want 3 0", rom_select, r_col_bad); end
    endtask

    task automatic test_player_clip();
        rom_mode = 1'b1; memory_select = 2'd3; draw_t = 1'b0; draw_p1 = 1'b1; draw_p2 = 1'b0;
        p1_x = 8'd156; p1_y = 7'd117;
        run_job(64, 8, 156, 117, 1'b0, 1'b0);
        vectors++; if (r_plots != 6) begin miscompares++; $display("FAIL clip_plot_count: got %0d want 6", r_plots); end
        vectors++; if (r_fx != 157 || r_fy != 117 || r_lx != 159 || r_ly != 119) begin miscompares++; $display("FAIL clip_first_last: got (%0d,%0d)..(%0d,%0d) want (157,117)..(159,119)", r_fx, r_fy, r_lx, r_ly); end
        vectors++; if (r_pos_bad != 0 || r_win_bad != 0 || r_col_bad != 0) begin miscompares++; $display("FAIL clip_pixels: got pos=%0d win=%0d col=%0d want 0 0 0", r_pos_bad, r_win_bad, r_col_bad); end
        vectors++; if (r_first_addr != 256 || r_fin_k != 66) begin miscompares++; $display("FAIL clip_addr_fin: got addr=%0d k=%0d want 256 66", r_first_addr, r_fin_k); end
        rom_mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        rom_mode = 1'b0; memory_select = 2'd3; draw_t = 1'b0; draw_p1 = 1'b1; draw_p2 = 1'b0;
        p1_x = 8'd10; p1_y = 7'd10; p2_x = 8'd40; p2_y = 7'd30;
        run_job(64, 8, 10, 10, 1'b1, 1'b0);
        vectors++; if (r_first_addr != 256 || r_fin_k != 66 || r_fin_cnt != 1 || r_plots != 56) begin miscompares++; $display("FAIL b2b_p1: got addr=%0d k=%0d n=%0d plots=%0d want 256 66 1 56", r_first_addr, r_fin_k, r_fin_cnt, r_plots); end
        draw_p1 = 1'b0; draw_p2 = 1'b1;
        run_job(64, 8, 40, 30, 1'b0, 1'b0);
        vectors++; if (r_first_addr != 320 || r_last_addr != 383 || r_addr_bad != 0) begin miscompares++; $display("FAIL b2b_p2_addr: got %0d..%0d bad=%0d want 320..383 0", r_first_addr, r_last_addr, r_addr_bad); end
        vectors++; if (r_fin_k != 66 || r_fin_cnt != 1 || r_plots != 56 || r_pos_bad != 0) begin miscompares++; $display("FAIL b2b_p2_job: got k=%0d n=%0d plots=%0d pos=%0d want 66 1 56 0", r_fin_k, r_fin_cnt, r_plots, r_pos_bad); end
    endtask

    task automatic test_reset_midjob();
        rom_mode = 1'b0; memory_select = 2'd1; draw_t = 1'b0; draw_p1 = 1'b0; draw_p2 = 1'b0;
        copy_enable = 1'b1;
        repeat (100) @(negedge clock);
        vectors++; if (vga_plot !== 1'b1 || rom_addr !== 15'd99) begin miscompares++; $display("FAIL midjob_running: got plot=%b addr=%0d want 1 99", vga_plot, rom_addr); end
        reset = 1'b1;
        @(negedge clock);
        vectors++; if (vga_plot !== 1'b0 || finished !== 1'b0 || rom_addr !== 15'd0 || rom_select !== 2'd0) begin miscompares++; $display("FAIL midjob_reset: got plot=%b fin=%b addr=%0d sel=%0d want 0 0 0 0", vga_plot, finished, rom_addr, rom_select); end
        vectors++; if (vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0) begin miscompares++; $display("FAIL midjob_reset_pix: got (%0d,%0d) c=%0d want (0,0) 0", vga_x, vga_y, vga_colour); end
        reset = 1'b0; copy_enable = 1'b0; memory_select = 2'd2;
        repeat (3) @(negedge clock);
        run_job(19200, 160, 0, 0, 1'b0, 1'b0);
        vectors++; if (r_first_addr != 0 || r_fin_k != 19202 || r_fin_cnt != 1 || r_plots != 19200) begin miscompares++; $display("FAIL restart_job: got addr=%0d k=%0d n=%0d plots=%0d want 0 19202 1 19200", r_first_addr, r_fin_k, r_fin_cnt, r_plots); end
        vectors++; if (rom_select !== 2'd2) begin miscompares++; $display("FAIL restart_rom_select: got %0d want 2", rom_select); end
    endtask

    task automatic test_priority();
        rom_mode = 1'b0; memory_select = 2'd3; draw_t = 1'b1; draw_p1 = 1'b0; draw_p2 = 1'b1;
        tile_x = 5'd1; tile_y = 4'd1; tile_id = 2'd2; p2_x = 8'd50; p2_y = 7'd50;
        run_job(64, 8, 8, 8, 1'b0, 1'b0);
        vectors++; if (r_first_addr != 128 || r_plots != 64 || r_pos_bad != 0) begin miscompares++; $display("FAIL prio_tile_over_p2: got addr=%0d plots=%0d pos=%0d want 128 64 0", r_first_addr, r_plots, r_pos_bad); end
        draw_t = 1'b0; draw_p2 = 1'b0; tile_id = 2'd3; tile_x = 5'd0; tile_y = 4'd0;
        run_job(64, 8, 0, 0, 1'b0, 1'b0);
        vectors++; if (r_first_addr != 192 || r_plots != 64 || r_fin_k != 66) begin miscompares++; $display("FAIL prio_default_tile: got addr=%0d plots=%0d k=%0d want 192 64 66", r_first_addr, r_plots, r_fin_k); end
    endtask

    initial begin
        test_reset();
        test_background();
        @(negedge clock);
        test_tile();
        @(negedge clock);
        test_player_clip();
        @(negedge clock);
        test_back_to_back();
        @(negedge clock);
        test_reset_midjob();
        @(negedge clock);
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
